// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver. Scans DIGITS codes at a programmable
// refresh rate and swaps in newly loaded codes only at frame boundaries.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  ready,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [0:6]            HEX,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  frame_end;
  logic                  pending;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic [4*DIGITS-1:0]   disp_val;
  logic [DIGITS-1:0]     disp_dp;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  lz_run;
  logic [DIGITS-1:0]     an_next;
  logic [0:6]            hex_next;

  // Glyph bits are ordered a..g, active-low.
  function automatic logic [0:6] glyph(input logic [3:0] code, input logic hex);
    logic [0:6] g;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!hex && code >= 4'd10) g = 7'b1111110;
    return g;
  endfunction

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == IDX_MAX);
  assign ready     = ~pending;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Handshake: ready is simply "nothing pending". A load only lands when pending is
  // clear, so a load coinciding with a boundary waits for the next boundary.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      pending  <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (frame_end && pending) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pending  <= 1'b0;
      end
      if (load && !pending) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end
    end
  end

  // lz_run stays 1 while every digit from the top down to i is zero.
  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    lz_run   = 1'b1;
    an_next  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (disp_val[4*i +: 4] == 4'd0);
      if (IW'(i) == idx) begin
        cur_code   = disp_val[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_lz     = lz_run && (i != 0);
        an_next[i] = 1'b0;
      end
    end
    hex_next = (blank_lz && cur_lz) ? 7'b1111111 : glyph(cur_code, hex_mode);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      AN  <= '1;
      HEX <= 7'b1111111;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      HEX <= hex_next;
      DP  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): expected per-slot outputs are
// queued when a load is driven and compared as each slot of the next frame appears.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       value;
  logic [3:0]        dp_in;
  logic              load;
  logic              ready;
  logic              hex_mode;
  logic              blank_lz;
  logic [0:6]        hex;
  logic              dp;
  logic [3:0]        an;

  logic [11:0]       exp_q[$];
  int                n_checks = 0;
  int                n_err    = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .ready    (ready),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .HEX      (hex),
    .DP       (dp),
    .AN       (an)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:6] ref_glyph(input logic [3:0] c, input logic hm);
    case (c)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'd10: return hm ? 7'b0001000 : 7'b1111110;
      4'd11: return hm ? 7'b1100000 : 7'b1111110;
      4'd12: return hm ? 7'b0110001 : 7'b1111110;
      4'd13: return hm ? 7'b1000010 : 7'b1111110;
      4'd14: return hm ? 7'b0110000 : 7'b1111110;
      default: return hm ? 7'b0111000 : 7'b1111110;
    endcase
  endfunction

  // Expected {AN, HEX, DP} while digit i is lit.
  function automatic logic [11:0] ref_slot(input logic [15:0] v, input logic [3:0] d,
                                           input logic hm, input logic blz, input int i);
    logic       blank;
    logic [3:0] an_e;
    logic [0:6] g;
    blank = blz && (i != 0);
    for (int j = i; j < DIGITS; j++)
      if (v[4*j +: 4] != 4'd0) blank = 1'b0;
    an_e    = 4'b1111;
    an_e[i] = 1'b0;
    g = blank ? 7'b1111111 : ref_glyph(v[4*i +: 4], hm);
    return {an_e, g, ~d[i]};
  endfunction

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input logic eq, input int budget);
    int k;
    k = 0;
    while (((an == pat) != eq) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((an == pat) != eq) chk("an_wait_timeout", an, pat);
  endtask

  task automatic load_push(input logic [15:0] v, input logic [3:0] d);
    wait_ready(40);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ready_drop", ready, 0);
    for (int i = 0; i < DIGITS; i++)
      exp_q.push_back(ref_slot(v, d, hex_mode, blank_lz, i));
  endtask

  task automatic check_frame(input string tag);
    logic [11:0] e;
    wait_ready(40);
    @(negedge clk);
    for (int i = 0; i < DIGITS; i++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_underflow"}, exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_an"},  an,  e[11:8]);
        chk({tag, "_hex"}, hex, e[7:1]);
        chk({tag, "_dp"},  dp,  e[0]);
      end
      repeat (RDIV) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hex", hex, 7'b1111111);
    chk("rst_dp", dp, 1);
    chk("rst_an", an, 4'b1111);
    chk("rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_an0", an, 4'b1110);
    chk("scan_hex0", hex, 7'b0000001);
    repeat (4) @(negedge clk);
    chk("scan_an1", an, 4'b1101);
    repeat (12) @(negedge clk);
    chk("scan_wrap", an, 4'b1110);

    // Hex glyphs with one decimal point.
    hex_mode = 1'b1;
    load_push(16'h1A3F, 4'b0100);
    check_frame("hexmode");

    // Decimal mode: C becomes a dash.
    hex_mode = 1'b0;
    load_push(16'h9C05, 4'b0000);
    check_frame("decmode");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_push(16'h0007, 4'b0000);
    check_frame("lz7");
    load_push(16'h0000, 4'b0000);
    check_frame("lz0");
    blank_lz = 1'b0;

    // Second load while busy is ignored.
    load_push(16'h1234, 4'b0001);
    value = 16'h5678;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_ready", ready, 0);
    check_frame("handshake");
    chk("hs_ready_back", ready, 1);

    // Load coinciding with the frame boundary waits a full frame.
    wait_an(4'b0111, 1'b0, 40);
    wait_an(4'b0111, 1'b1, 40);
    repeat (2) @(negedge clk);
    value = 16'h4321;
    dp_in = 4'b0000;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_ready", ready, 0);
    @(negedge clk);
    chk("bnd_old_an", an, 4'b1110);
    chk("bnd_old_hex", hex, 7'b1001100);
    for (int i = 0; i < DIGITS; i++)
      exp_q.push_back(ref_slot(16'h4321, 4'b0000, hex_mode, blank_lz, i));
    check_frame("boundary");

    // Reset with a pending value mid-frame discards it.
    wait_an(4'b1110, 1'b1, 40);
    value = 16'h8888;
    dp_in = 4'b1111;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_an(4'b1011, 1'b1, 40);
    chk("mid_pending", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hex", hex, 7'b1111111);
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_dp", dp, 1);
    chk("mid_rst_ready", ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_an", an, 4'b1110);
    for (int k = 0; k < 20; k++) begin
      chk("restart_hex", hex, 7'b0000001);
      chk("restart_dp", dp, 1);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
